// File: rtl/hazard_controller_if.sv
// Datapath <-> hazard controller bundle: ID/EX/MEM/WB register-use info in,
// stall/flush/forward controls and performance counters out.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IDRs;
  logic [4:0]       IDRt;
  logic             IDUsesRt;
  logic [4:0]       EXRs;
  logic [4:0]       EXRt;
  logic             EXRegWrite;
  logic             EXMemRead;
  logic [4:0]       EXDest;
  logic             MEMRegWrite;
  logic [4:0]       MEMDest;
  logic             WBRegWrite;
  logic [4:0]       WBDest;
  logic             BranchTaken;
  logic             JumpTaken;
  logic             PCStall;
  logic             IFIDStall;
  logic             IDEXBubble;
  logic             Flush;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [1:0]       StallCount;
  logic [1:0]       HazardState;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IDRs, IDRt, IDUsesRt, EXRs, EXRt, EXRegWrite, EXMemRead, EXDest,
           MEMRegWrite, MEMDest, WBRegWrite, WBDest, BranchTaken, JumpTaken,
    input  PCStall, IFIDStall, IDEXBubble, Flush, ForwardA, ForwardB,
           StallCount, HazardState, StallCycles, FlushCount
  );

  modport slave (
    input  IDRs, IDRt, IDUsesRt, EXRs, EXRt, EXRegWrite, EXMemRead, EXDest,
           MEMRegWrite, MEMDest, WBRegWrite, WBDest, BranchTaken, JumpTaken,
    output PCStall, IFIDStall, IDEXBubble, Flush, ForwardA, ForwardB,
           StallCount, HazardState, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage MIPS hazard controller: RAW stall, MEM-stage redirect flush, perf counters.
// Define FORWARDING_EN to enable EX operand forwarding with load-use-only stalls.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input logic            Clk,
  input logic            Reset,
  hazard_controller_if.slave hc
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} hstate_e;

  hstate_e          state;
  logic [1:0]       stallCnt;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;
  logic             matchEx;
  logic             redirect;
  logic [1:0]       needStall;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             stallNow;
  logic             flushNow;

  function automatic logic hit(input logic we, input logic [4:0] dest,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt);
    return we && (dest != 5'd0) && ((dest == rs) || (usesRt && (dest == rt)));
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  assign matchEx  = hit(hc.EXRegWrite, hc.EXDest, hc.IDRs, hc.IDRt, hc.IDUsesRt);
  assign redirect = hc.BranchTaken || hc.JumpTaken;

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                        input logic memWe, input logic [4:0] memDest,
                                        input logic wbWe, input logic [4:0] wbDest);
    if (memWe && (memDest != 5'd0) && (memDest == src)) return 2'b01;
    if (wbWe && (wbDest != 5'd0) && (wbDest == src))    return 2'b10;
    return 2'b00;
  endfunction

  // Only a load in EX cannot be forwarded in time
  always_comb begin
    needStall = (matchEx && hc.EXMemRead) ? 2'd1 : 2'd0;
    fwdA = fwdSel(hc.EXRs, hc.MEMRegWrite, hc.MEMDest, hc.WBRegWrite, hc.WBDest);
    fwdB = fwdSel(hc.EXRt, hc.MEMRegWrite, hc.MEMDest, hc.WBRegWrite, hc.WBDest);
  end
`else
  logic matchMem;
  logic matchWb;
  logic unusedFwdSrc;

  assign matchMem     = hit(hc.MEMRegWrite, hc.MEMDest, hc.IDRs, hc.IDRt, hc.IDUsesRt);
  assign matchWb      = hit(hc.WBRegWrite, hc.WBDest, hc.IDRs, hc.IDRt, hc.IDUsesRt);
  assign unusedFwdSrc = ^{hc.EXRs, hc.EXRt, hc.EXMemRead};

  // Wait until the producer has written the register file
  always_comb begin
    needStall = 2'd0;
    if (matchEx)       needStall = 2'd3;
    else if (matchMem) needStall = 2'd2;
    else if (matchWb)  needStall = 2'd1;
    fwdA = 2'b00;
    fwdB = 2'b00;
  end
`endif

  always_comb begin
    stallNow = 1'b0;
    flushNow = 1'b0;
    if (redirect) flushNow = 1'b1;
    else begin
      case (state)
        RUN:     stallNow = (needStall != 2'd0);
        STALL:   stallNow = 1'b1;
        default: stallNow = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= RUN;
      stallCnt    <= 2'd0;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      stallCycles <= satInc(stallCycles, stallNow);
      flushCount  <= satInc(flushCount, flushNow);
      if (redirect) begin
        state    <= FLUSH;
        stallCnt <= 2'd0;
      end else begin
        case (state)
          RUN: begin
            if (needStall != 2'd0) begin
              stallCnt <= needStall - 2'd1;
              state    <= (needStall > 2'd1) ? STALL : RUN;
            end
          end
          STALL: begin
            stallCnt <= stallCnt - 2'd1;
            if (stallCnt == 2'd1) state <= RUN;
          end
          default: begin
            state    <= RUN;
            stallCnt <= 2'd0;
          end
        endcase
      end
    end
  end

  // Combinational outputs are forced low while reset is held
  assign hc.PCStall     = Reset && stallNow;
  assign hc.IFIDStall   = Reset && stallNow;
  assign hc.IDEXBubble  = Reset && stallNow;
  assign hc.Flush       = Reset && flushNow;
  assign hc.ForwardA    = Reset ? fwdA : 2'b00;
  assign hc.ForwardB    = Reset ? fwdB : 2'b00;
  assign hc.StallCount  = stallCnt;
  assign hc.HazardState = state;
  assign hc.StallCycles = stallCycles;
  assign hc.FlushCount  = flushCount;
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the five-stage MIPS datapath (IF/ID/EX/MEM/WB). It detects RAW hazards between the instruction in ID and the producers in EX/MEM/WB, and stalls PC and IF/ID while injecting ID/EX bubbles. It issues the flush on a MEM-stage branch or jump redirect. It replaces the ad-hoc stall/flush logic feeding ProgramCounter, IF_ID, ID_EX, EX_MEM and MEM_WB, and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of the performance counters StallCycles and FlushCount.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
IDRs  in  5  rs field of the instruction in ID.
IDRt  in  5  rt field of the instruction in ID.
IDUsesRt  in  1  ID instruction reads rt (R-type, branch, store).
EXRs  in  5  rs of the instruction in EX (forwarding only).
EXRt  in  5  rt of the instruction in EX (forwarding only).
EXRegWrite  in  1  EX instruction writes the register file.
EXMemRead  in  1  EX instruction is a load.
EXDest  in  5  EX destination register (RegDst mux output).
MEMRegWrite  in  1  MEM instruction writes the register file.
MEMDest  in  5  MEM destination register.
WBRegWrite  in  1  WB instruction writes the register file.
WBDest  in  5  WB destination register.
BranchTaken  in  1  taken branch resolved in MEM.
JumpTaken  in  1  j/jal/jr redirect in MEM (PipeJump != 0).
PCStall  out  1  hold PC.
IFIDStall  out  1  hold IF/ID.
IDEXBubble  out  1  load NOP (all control signals 0) into ID/EX.
Flush  out  1  clear IF/ID, ID/EX and EX/MEM on the next edge.
ForwardA  out  2  EX operand A source: 00 = register file, 01 = EX/MEM ALU result, 10 = WB write data.
ForwardB  out  2  EX operand B source, same encoding as ForwardA.
StallCount  out  2  remaining stall cycles.
HazardState  out  2  00 RUN, 01 STALL, 10 FLUSH.
StallCycles  out  CNT_W  saturating count of cycles with PCStall = 1.
FlushCount  out  CNT_W  saturating count of Flush pulses.

Behaviour:
- Reset low, asynchronous: state RUN, StallCount 0, both counters 0. All outputs 0.
- Match definitions. match(X) = XRegWrite && XDest != 0 && (XDest == IDRs || (IDUsesRt && XDest == IDRt)), for X in EX, MEM, WB.
- Register file writes on the Clk edge, so WB data is readable by ID the cycle after WB.
- Required stall, no forwarding: 3 if match(EX), else 2 if match(MEM), else 1 if match(WB), else 0.
- Required stall, with forwarding: 1 if match(EX) && EXMemRead, else 0.
- Redirect = BranchTaken || JumpTaken. It has absolute priority in every state.
- A redirect cycle drives Flush = 1, PCStall = 0, IFIDStall = 0, IDEXBubble = 0. Next state is FLUSH; StallCount is cleared and any stall in progress is abandoned.
- RUN:
  - Required stall N > 0: PCStall = IFIDStall = IDEXBubble = 1 in this same cycle (Mealy). StallCount loads N-1. Next state is STALL if N-1 > 0, else RUN.
- STALL:
  - PCStall = IFIDStall = IDEXBubble = 1. StallCount decrements.
  - Next state is RUN when StallCount == 1. The hazard is not re-evaluated during STALL.
- FLUSH:
  - Lasts exactly one cycle. Hazard detection is masked (ID holds a flushed NOP). All control outputs are 0. Next state is RUN.
- Control outputs in STALL and FLUSH are Moore outputs; PCStall/IFIDStall/IDEXBubble/Flush in RUN are combinational.
- A stall therefore spans exactly N consecutive cycles with a single ID instruction held.
- Counters: StallCycles += 1 on each PCStall cycle, FlushCount += 1 on each Flush cycle. Both saturate at all-ones and never wrap.
- Register 0 is never a hazard source.

Optional Feature:
FORWARDING_EN
- Defined: uses the forwarding stall rule above.
  - ForwardA = 01 if MEMRegWrite && MEMDest != 0 && MEMDest == EXRs; else 10 if the WB equivalent holds; else 00.
  - ForwardB is the same rule using EXRt.
  - MEM has priority over WB. ForwardA/ForwardB are combinational.
- Undefined: uses the no-forwarding stall rule. ForwardA = ForwardB = 00 constantly, and EXRs/EXRt are ignored.

Test Plan:
1. Reset low mid-STALL (StallCount 2) -> all outputs 0 and HazardState 00 immediately, without waiting for a clock edge; counters 0.
2. No FORWARDING_EN, EXRegWrite = 1, EXDest = 8, IDRs = 8 -> PCStall/IFIDStall/IDEXBubble high for exactly 3 cycles, then low; StallCycles = 3.
3. FORWARDING_EN, EXMemRead = 1, EXDest = 9, IDRt = 9, IDUsesRt = 1 -> 1-cycle stall. Non-load EXDest = 9 -> no stall, and ForwardB = 01 once the producer reaches MEM.
4. EXDest = 0 with EXRegWrite = 1 and IDRs = 0 -> no stall, ForwardA = 00.
5. BranchTaken = 1 in the second cycle of a 3-cycle stall -> Flush = 1 and PCStall = 0 that cycle, HazardState 10 next cycle, then 00; FlushCount = 1.
6. CNT_W = 2, with 5 stall cycles -> StallCycles saturates at 3.
